// File: rtl/dram_bus_pkg.sv
// Shared types and AXI encodings for the DRAM AXI master.
package dram_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AWW,
    ST_B,
    ST_DONE
  } dram_axi_state_t;

  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/dram_axi_master_if.sv
// Single-beat AXI4 port (AW/W/B/AR/R) between the DRAM master and the external slave.
interface dram_axi_if;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;

  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic [3:0]  arqos;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/dram_axi_master.sv
// Converts the DMA controller's level-held DRAM request into one registered,
// fully handshaked AXI4 single-beat transaction with a one-cycle completion pulse.
//
// state | meaning
// IDLE  | waiting for readEnable/writeEnable; request address/data captured here
// AR    | arvalid held until arready
// R     | rready high, waiting for rvalid
// AWW   | awvalid/wvalid each held until its own handshake
// B     | bready high, waiting for bvalid
// DONE  | dramValid pulse, enables ignored
module dram_axi_master
  import dram_bus_pkg::*;
#(
  parameter logic [3:0] WR_ID = 4'd1,
  parameter logic [3:0] RD_ID = 4'd2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dramAddress,
  input  logic [31:0] dramWriteData,
  input  logic        readEnable,
  input  logic        writeEnable,
  output logic [31:0] dramReadData,
  output logic        dramValid,
  output logic        dramError,
  dram_axi_if.master  m_axi
);

  dram_axi_state_t state_q, state_d;
  logic        aw_done_q, w_done_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic        err_q;
  logic        aw_fire, w_fire;
  logic        unused_axi;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (writeEnable)     state_d = ST_AWW;
        else if (readEnable) state_d = ST_AR;
      end
      ST_AR:   if (m_axi.arready) state_d = ST_R;
      ST_R:    if (m_axi.rvalid)  state_d = ST_DONE;
      ST_AWW:  if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) state_d = ST_B;
      ST_B:    if (m_axi.bvalid)  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // VALID/READY come only from state and flag flops, never from slave inputs.
  assign m_axi.arvalid = (state_q == ST_AR);
  assign m_axi.rready  = (state_q == ST_R);
  assign m_axi.awvalid = (state_q == ST_AWW) && !aw_done_q;
  assign m_axi.wvalid  = (state_q == ST_AWW) && !w_done_q;
  assign m_axi.bready  = (state_q == ST_B);
  assign dramValid     = (state_q == ST_DONE);

  assign aw_fire = m_axi.awvalid && m_axi.awready;
  assign w_fire  = m_axi.wvalid && m_axi.wready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      if (state_q == ST_AWW) begin
        if (aw_fire) aw_done_q <= 1'b1;
        if (w_fire)  w_done_q  <= 1'b1;
      end else begin
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end
      if (state_q == ST_IDLE && (writeEnable || readEnable)) begin
        addr_q  <= dramAddress;
        wdata_q <= dramWriteData;
      end
      if (state_q == ST_R && m_axi.rvalid) begin
        rdata_q <= m_axi.rdata;
        err_q   <= m_axi.rresp[1];
      end
      if (state_q == ST_B && m_axi.bvalid) begin
        err_q <= m_axi.bresp[1];
      end
    end
  end

  assign dramReadData = rdata_q;
  assign dramError    = err_q;

  assign m_axi.awid    = WR_ID;
  assign m_axi.awaddr  = addr_q;
  assign m_axi.awlen   = 8'd0;
  assign m_axi.awsize  = AXI_SIZE_4B;
  assign m_axi.awburst = AXI_BURST_INCR;
  assign m_axi.awlock  = 1'b0;
  assign m_axi.awcache = 4'd0;
  assign m_axi.awprot  = 3'd0;

  assign m_axi.wdata = wdata_q;
  assign m_axi.wstrb = 4'hF;
  assign m_axi.wlast = 1'b1;

  assign m_axi.arid    = RD_ID;
  assign m_axi.araddr  = addr_q;
  assign m_axi.arlen   = 8'd0;
  assign m_axi.arsize  = AXI_SIZE_4B;
  assign m_axi.arburst = AXI_BURST_INCR;
  assign m_axi.arlock  = 1'b0;
  assign m_axi.arcache = 4'd0;
  assign m_axi.arprot  = 3'd0;
  assign m_axi.arqos   = 4'd0;

  // Single-beat, single-ID traffic: IDs, rlast and the low RESP bit carry no information here.
  assign unused_axi = ^{m_axi.bid, m_axi.bresp[0], m_axi.rid, m_axi.rresp[0], m_axi.rlast};

endmodule

// File: tb/tb_dram_axi_master.sv
// Directed scoreboard bench for dram_axi_master: latency, VALID holding, write priority, errors, reset abort.
module tb_dram_axi_master;
  import dram_bus_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dramAddress, dramWriteData, dramReadData;
  logic        readEnable, writeEnable, dramValid, dramError;

  always #5 clk = ~clk;

  dram_axi_if m_axi ();

  dram_axi_master #(.WR_ID(4'd1), .RD_ID(4'd2)) dut (
    .clk          (clk),
    .reset        (reset),
    .dramAddress  (dramAddress),
    .dramWriteData(dramWriteData),
    .readEnable   (readEnable),
    .writeEnable  (writeEnable),
    .dramReadData (dramReadData),
    .dramValid    (dramValid),
    .dramError    (dramError),
    .m_axi        (m_axi)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_rdata;
  int          checks = 0;
  int          failures = 0;
  int          aw_hs = 0, w_hs = 0, ar_hs = 0;
  int          aw_base, w_base, ar_base, awc, wc;

  // Handshakes are counted just before each rising edge, when both sides are stable.
  initial forever begin
    @(negedge clk);
    #4;
    if (!reset) begin
      if (m_axi.awvalid && m_axi.awready) aw_hs++;
      if (m_axi.wvalid && m_axi.wready)   w_hs++;
      if (m_axi.arvalid && m_axi.arready) ar_hs++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] rdata, input logic err);
    exp_t e;
    e.rdata = rdata;
    e.err   = err;
    sb.push_back(e);
  endtask

  // Waits (bounded) for dramValid, checks latency in negedges and the scoreboard entry,
  // then drops the enables as the requester does after completion.
  task automatic wait_done(input string tag, input int exp_lat);
    int   n;
    exp_t e;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dramValid !== 1'b1 && n < 40);
    check1({tag, "_valid"}, dramValid, 1'b1);
    if (exp_lat > 0) check({tag, "_latency"}, n, exp_lat);
    check({tag, "_sb_depth"}, sb.size(), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_rdata"}, dramReadData, e.rdata);
      check1({tag, "_error"}, dramError, e.err);
    end
    readEnable  = 1'b0;
    writeEnable = 1'b0;
    @(negedge clk);
    check1({tag, "_pulse_end"}, dramValid, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    dramAddress = '0; dramWriteData = '0; readEnable = 1'b0; writeEnable = 1'b0;
    m_axi.awready = 1'b1; m_axi.wready = 1'b1;
    m_axi.bid = 4'd1; m_axi.bresp = AXI_RESP_OKAY; m_axi.bvalid = 1'b1;
    m_axi.arready = 1'b1;
    m_axi.rid = 4'd2; m_axi.rdata = '0; m_axi.rresp = AXI_RESP_OKAY; m_axi.rlast = 1'b1; m_axi.rvalid = 1'b1;
    exp_rdata = '0;

    // Reset state and constant fields
    @(negedge clk);
    @(negedge clk);
    check1("rst_arvalid", m_axi.arvalid, 1'b0);
    check1("rst_awvalid", m_axi.awvalid, 1'b0);
    check1("rst_wvalid", m_axi.wvalid, 1'b0);
    check1("rst_rready", m_axi.rready, 1'b0);
    check1("rst_bready", m_axi.bready, 1'b0);
    check1("rst_dramValid", dramValid, 1'b0);
    check1("rst_dramError", dramError, 1'b0);
    check("rst_readData", dramReadData, 32'h0);
    check("const_ids", {24'h0, m_axi.awid, m_axi.arid}, 32'h12);
    check("const_len", {16'h0, m_axi.awlen, m_axi.arlen}, 32'h0);
    check("const_size_burst", {22'h0, m_axi.awsize, m_axi.arsize, m_axi.awburst, m_axi.arburst}, {22'h0, 3'b010, 3'b010, 2'b01, 2'b01});
    check("const_misc", {m_axi.awlock, m_axi.arlock, m_axi.awcache, m_axi.arcache, m_axi.awprot, m_axi.arprot, m_axi.arqos},
          32'h0);
    check("const_w", {27'h0, m_axi.wstrb, m_axi.wlast}, 32'h1F);
    reset = 1'b0;

    // 1: zero-wait read
    @(negedge clk);
    readEnable = 1'b1; dramAddress = 32'h1000;
    m_axi.rdata = 32'hDEADBEEF; m_axi.rresp = AXI_RESP_OKAY;
    exp_rdata = 32'hDEADBEEF; push_exp(exp_rdata, 1'b0);
    @(negedge clk);
    check1("t1_arvalid_n1", m_axi.arvalid, 1'b1);
    check1("t1_rready_n1", m_axi.rready, 1'b0);
    check("t1_araddr", m_axi.araddr, 32'h1000);
    @(negedge clk);
    check1("t1_arvalid_n2", m_axi.arvalid, 1'b0);
    check1("t1_rready_n2", m_axi.rready, 1'b1);
    wait_done("t1", 1);

    // 2: write with awready delayed 3 cycles, wready immediate
    m_axi.awready = 1'b0; m_axi.wready = 1'b1; m_axi.bvalid = 1'b0;
    aw_base = aw_hs; w_base = w_hs; awc = 0; wc = 0;
    writeEnable = 1'b1; dramAddress = 32'h2004; dramWriteData = 32'h12345678;
    push_exp(exp_rdata, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (m_axi.awvalid) awc++;
      if (m_axi.wvalid)  wc++;
      if (k == 1) check1("t2_wvalid_c1", m_axi.wvalid, 1'b1);
      if (k == 2) check1("t2_wvalid_c2", m_axi.wvalid, 1'b0);
      if (k == 4) m_axi.awready = 1'b1;
    end
    check("t2_awaddr", m_axi.awaddr, 32'h2004);
    check("t2_wdata", m_axi.wdata, 32'h12345678);
    @(negedge clk);
    check1("t2_bready", m_axi.bready, 1'b1);
    check1("t2_awvalid_dropped", m_axi.awvalid, 1'b0);
    check("t2_awvalid_cycles", awc, 32'd4);
    check("t2_wvalid_cycles", wc, 32'd1);
    m_axi.bvalid = 1'b1;
    wait_done("t2", 1);
    check("t2_aw_handshakes", aw_hs - aw_base, 32'd1);
    check("t2_w_handshakes", w_hs - w_base, 32'd1);

    // 3: arready low for 5 cycles while the address input wanders
    m_axi.arready = 1'b0;
    ar_base = ar_hs;
    readEnable = 1'b1; dramAddress = 32'h1000;
    m_axi.rdata = 32'hCAFEF00D;
    exp_rdata = 32'hCAFEF00D; push_exp(exp_rdata, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check1("t3_arvalid_held", m_axi.arvalid, 1'b1);
      check("t3_araddr_held", m_axi.araddr, 32'h1000);
      dramAddress = $urandom;
    end
    m_axi.arready = 1'b1;
    wait_done("t3", 2);
    check("t3_ar_handshakes", ar_hs - ar_base, 32'd1);

    // 4: both enables high, write goes first; read only after re-assertion
    ar_base = ar_hs; aw_base = aw_hs;
    writeEnable = 1'b1; readEnable = 1'b1;
    dramAddress = 32'h3000; dramWriteData = 32'hA5A5A5A5;
    push_exp(exp_rdata, 1'b0);
    @(negedge clk);
    check1("t4_awvalid", m_axi.awvalid, 1'b1);
    check1("t4_arvalid", m_axi.arvalid, 1'b0);
    check("t4_wdata", m_axi.wdata, 32'hA5A5A5A5);
    wait_done("t4w", 2);
    check("t4_aw_handshakes", aw_hs - aw_base, 32'd1);
    @(negedge clk);
    check1("t4_idle_arvalid", m_axi.arvalid, 1'b0);
    check("t4_no_read_yet", ar_hs - ar_base, 32'd0);
    readEnable = 1'b1; dramAddress = 32'h3000;
    m_axi.rdata = 32'h0BADF00D;
    exp_rdata = 32'h0BADF00D; push_exp(exp_rdata, 1'b0);
    wait_done("t4r", 3);
    check("t4_read_issued", ar_hs - ar_base, 32'd1);

    // 5: SLVERR on write, cleared by next OKAY read
    m_axi.bresp = 2'b10;
    writeEnable = 1'b1; dramAddress = 32'h4000; dramWriteData = 32'h00000001;
    push_exp(exp_rdata, 1'b1);
    wait_done("t5w", 3);
    m_axi.bresp = AXI_RESP_OKAY;
    readEnable = 1'b1; dramAddress = 32'h4000;
    m_axi.rdata = 32'h600DF00D;
    exp_rdata = 32'h600DF00D; push_exp(exp_rdata, 1'b0);
    wait_done("t5r", 3);

    // 6: reset while in R, then a normal read
    m_axi.rvalid = 1'b0;
    readEnable = 1'b1; dramAddress = 32'h5000;
    push_exp(32'h0, 1'b0);
    @(negedge clk);
    check1("t6_arvalid", m_axi.arvalid, 1'b1);
    @(negedge clk);
    check1("t6_in_r", m_axi.rready, 1'b1);
    reset = 1'b1; readEnable = 1'b0;
    sb.delete();
    exp_rdata = 32'h0;
    @(negedge clk);
    check1("t6_rready", m_axi.rready, 1'b0);
    check1("t6_arvalid_rst", m_axi.arvalid, 1'b0);
    check1("t6_awvalid", m_axi.awvalid, 1'b0);
    check1("t6_wvalid", m_axi.wvalid, 1'b0);
    check1("t6_bready", m_axi.bready, 1'b0);
    check1("t6_dramValid", dramValid, 1'b0);
    check("t6_state", 32'(dut.state_q), 32'(ST_IDLE));
    check("t6_readData", dramReadData, 32'h0);
    reset = 1'b0;
    m_axi.rvalid = 1'b1; m_axi.rdata = 32'h5555AAAA;
    @(negedge clk);
    readEnable = 1'b1; dramAddress = 32'h5000;
    exp_rdata = 32'h5555AAAA; push_exp(exp_rdata, 1'b0);
    wait_done("t6r", 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
